// File: rtl/rule_match_collector_pkg.sv
// ============================================================================
// Module   : rule_match_collector_pkg
// Brief    : Shared rule-ID width, output beat type and helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rule_match_collector_pkg;

    localparam int RULE_AWIDTH    = 16;
    localparam int DROP_CNT_WIDTH = 16;

    typedef struct packed {
        logic                   last;
        logic [RULE_AWIDTH-1:0] rule;
    } rule_out_t;

    localparam logic [RULE_AWIDTH-1:0] RULE_NONE = '0;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rule_match_collector_if.sv
// ============================================================================
// Module   : rule_match_collector_if
// Brief    : Match-stream input, beat output stream and status flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rule_match_collector_if;
    import rule_match_collector_pkg::*;

    logic [RULE_AWIDTH-1:0]    in_rule_data;
    logic                      in_rule_match;
    logic                      in_eop;
    logic [RULE_AWIDTH-1:0]    out_data;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
    logic                      almost_full;
    logic                      overflow;
    logic                      protocol_err;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    modport slave (
        input  in_rule_data, in_rule_match, in_eop, out_ready,
        output out_data, out_last, out_valid, almost_full, overflow, protocol_err, drop_cnt
    );

    modport master (
        output in_rule_data, in_rule_match, in_eop, out_ready,
        input  out_data, out_last, out_valid, almost_full, overflow, protocol_err, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/rule_match_collector_rule_fifo.sv
// ============================================================================
// Module   : rule_fifo
// Brief    : Synchronous show-ahead FIFO of rule_out_t (DEPTH power of 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rule_fifo
    import rule_match_collector_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  rule_out_t              i_wr_data,
    input  logic                   i_rd_en,
    output rule_out_t              o_rd_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    rule_out_t r_mem [DEPTH];
    ptr_t      r_wptr;
    ptr_t      r_rptr;
    cnt_t      r_count;
    logic      w_push;
    logic      w_pop;

    // Full is judged on the pre-edge count, so a same-cycle read never makes room.
    assign o_full    = (r_count == cnt_t'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ptr_t'(1);
            end
            r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rule_match_collector.sv
// ============================================================================
// Module   : rule_match_collector
// Brief    : Dedups per-packet rule matches and emits one rule ID per beat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rule_match_collector
    import rule_match_collector_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int AF_MARGIN  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    rule_match_collector_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t c_AF_THRESH = cnt_t'(FIFO_DEPTH - AF_MARGIN);

    logic                      r_pend_valid;
    logic [RULE_AWIDTH-1:0]    r_pend_rule;
    logic                      r_almost_full;
    logic                      r_overflow;
    logic                      r_protocol_err;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    logic                      w_is_match;
    logic                      w_is_dup;
    logic                      w_wr_en;
    rule_out_t                 w_wr_data;
    rule_out_t                 w_head;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      w_push;
    logic                      w_pop;
    cnt_t                      w_count;
    cnt_t                      w_count_nxt;

    // A match coinciding with eop is ignored; eop always wins.
    assign w_is_match = bus.in_rule_match && !bus.in_eop;
    assign w_is_dup   = r_pend_valid && (bus.in_rule_data == r_pend_rule);

    always_comb begin
        w_wr_en        = 1'b0;
        w_wr_data.last = 1'b0;
        w_wr_data.rule = r_pend_rule;
        if (bus.in_eop) begin
            w_wr_en        = 1'b1;
            w_wr_data.last = 1'b1;
            w_wr_data.rule = r_pend_valid ? r_pend_rule : RULE_NONE;
        end else if (w_is_match && r_pend_valid && !w_is_dup) begin
            w_wr_en = 1'b1;
        end
    end

    rule_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_rule_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (bus.out_ready),
        .o_rd_data (w_head),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full),
        .o_count   (w_count)
    );

    // Post-edge occupancy, so almost_full lines up with the FIFO contents it describes.
    assign w_push      = w_wr_en && !w_fifo_full;
    assign w_pop       = bus.out_ready && !w_fifo_empty;
    assign w_count_nxt = w_count + cnt_t'(w_push) - cnt_t'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_rule  <= RULE_NONE;
        end else if (bus.in_eop) begin
            r_pend_valid <= 1'b0;
        end else if (w_is_match && !w_is_dup) begin
            r_pend_valid <= 1'b1;
            r_pend_rule  <= bus.in_rule_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            r_almost_full <= (w_count_nxt >= c_AF_THRESH);
            if (w_wr_en && w_fifo_full) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
            if (bus.in_rule_match && bus.in_eop) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid    = !w_fifo_empty;
    assign bus.out_data     = w_head.rule;
    assign bus.out_last     = w_head.last;
    assign bus.almost_full  = r_almost_full;
    assign bus.overflow     = r_overflow;
    assign bus.protocol_err = r_protocol_err;
    assign bus.drop_cnt     = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rule_match_collector.sv
// ============================================================================
// Module   : tb_rule_match_collector
// Brief    : Directed self-checking bench for rule_match_collector.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rule_match_collector;
    import rule_match_collector_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rule_match_collector_if bus();

    rule_match_collector #(
        .FIFO_DEPTH (16),
        .AF_MARGIN  (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] rx_q[$];
    logic [16:0] exp_q[$];
    bit          ready_rand = 1'b0;
    logic        ready_val  = 1'b1;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_beat  = '0;
    bit          m_pv;
    logic [15:0] m_pr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Beat capture plus hold-during-stall check.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall_stable", 32'({bus.out_last, bus.out_data}), 32'(prev_beat));
            if (bus.out_valid && bus.out_ready)
                rx_q.push_back({bus.out_last, bus.out_data});
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_beat  <= {bus.out_last, bus.out_data};
        end
    end

    task automatic drive(input logic m, input logic e, input logic [15:0] d);
        bus.in_rule_match = m;
        bus.in_eop        = e;
        bus.in_rule_data  = d;
        bus.out_ready     = ready_rand ? ($urandom_range(0, 1) == 1) : ready_val;
        @(posedge clk);
        #1;
        bus.in_rule_match = 1'b0;
        bus.in_eop        = 1'b0;
    endtask

    task automatic model_match(input logic [15:0] id);
        if (!(m_pv && id == m_pr)) begin
            if (m_pv) exp_q.push_back({1'b0, m_pr});
            m_pr = id;
            m_pv = 1'b1;
        end
    endtask

    task automatic model_eop();
        exp_q.push_back({1'b1, m_pv ? m_pr : 16'd0});
        m_pv = 1'b0;
    endtask

    task automatic wait_room();
        int c = 0;
        while (bus.almost_full && c < 200) begin
            drive(1'b0, 1'b0, 16'd0);
            c++;
        end
    endtask

    task automatic drain(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            drive(1'b0, 1'b0, 16'd0);
            c++;
        end
        repeat (3) drive(1'b0, 1'b0, 16'd0);
    endtask

    task automatic cmp_queues(input string tag);
        int n;
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid),    32'd0);
        check({tag, "_data"},  32'(bus.out_data),     32'd0);
        check({tag, "_last"},  32'(bus.out_last),     32'd0);
        check({tag, "_af"},    32'(bus.almost_full),  32'd0);
        check({tag, "_ovf"},   32'(bus.overflow),     32'd0);
        check({tag, "_perr"},  32'(bus.protocol_err), 32'd0);
        check({tag, "_drops"}, 32'(bus.drop_cnt),     32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int occ;
        rst               = 1'b1;
        bus.in_rule_match = 1'b0;
        bus.in_eop        = 1'b0;
        bus.in_rule_data  = '0;
        bus.out_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Dedup of back-to-back 9s, last on the final match.
        drive(1'b1, 1'b0, 16'd5);
        drive(1'b1, 1'b0, 16'd9);
        drive(1'b1, 1'b0, 16'd9);
        drive(1'b1, 1'b0, 16'd12);
        drive(1'b0, 1'b1, 16'd0);
        exp_q.push_back({1'b0, 16'd5});
        exp_q.push_back({1'b0, 16'd9});
        exp_q.push_back({1'b1, 16'd12});
        drain(3, 20);
        cmp_queues("dedup");

        // Match-less packets produce a single rule-0 beat each.
        drive(1'b0, 1'b1, 16'd0);
        check("eop_latency_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 1'b0, 16'd0);
        drive(1'b0, 1'b1, 16'd0);
        drive(1'b0, 1'b0, 16'd0);
        drive(1'b0, 1'b1, 16'd0);
        repeat (3) exp_q.push_back({1'b1, 16'd0});
        drain(3, 20);
        cmp_queues("empty_pkt");

        // Match together with eop: match dropped, error flagged.
        drive(1'b1, 1'b0, 16'd3);
        drive(1'b1, 1'b1, 16'd7);
        check("perr_set", 32'(bus.protocol_err), 32'd1);
        exp_q.push_back({1'b1, 16'd3});
        drain(1, 20);
        cmp_queues("collide");
        check("perr_sticky", 32'(bus.protocol_err), 32'd1);

        // Overflow with the consumer stalled.
        ready_val = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b0, 16'(100 + i));
            occ = (i - 1 > 16) ? 16 : i - 1;
            check($sformatf("af_after_match%0d", i), 32'(bus.almost_full), (occ >= 8) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b1, 16'd0);
        check("ovf_af",    32'(bus.almost_full), 32'd1);
        check("ovf_flag",  32'(bus.overflow),    32'd1);
        check("ovf_drops", 32'(bus.drop_cnt),    32'd4);
        check("ovf_head",  32'({bus.out_valid, bus.out_last, bus.out_data}), 32'({1'b1, 1'b0, 16'd101}));
        for (int i = 1; i <= 16; i++) exp_q.push_back({1'b0, 16'(100 + i)});
        ready_val = 1'b1;
        drain(16, 40);
        cmp_queues("ovf_drain");
        check("ovf_af_clear", 32'(bus.almost_full), 32'd0);

        // Random backpressure against the packet model.
        ready_rand = 1'b1;
        m_pv       = 1'b0;
        m_pr       = '0;
        for (int p = 0; p < 10; p++) begin
            for (int k = 1; k <= 10; k++) begin
                wait_room();
                drive(1'b1, 1'b0, 16'(p * 10 + k));
                model_match(16'(p * 10 + k));
                if (k % 3 == 0) begin
                    wait_room();
                    drive(1'b1, 1'b0, 16'(p * 10 + k));
                    model_match(16'(p * 10 + k));
                end
            end
            wait_room();
            drive(1'b0, 1'b1, 16'd0);
            model_eop();
        end
        ready_rand = 1'b0;
        ready_val  = 1'b1;
        drain(exp_q.size(), 300);
        cmp_queues("rand");
        check("rand_drops", 32'(bus.drop_cnt), 32'd4);

        // Reset mid-packet with pending=4 and three queued entries.
        ready_val = 1'b0;
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 16'(i));
        check("prerst_head", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, 16'd1}));
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'd0);
        check_reset_vals("midrst");
        rst       = 1'b0;
        ready_val = 1'b1;
        drive(1'b0, 1'b1, 16'd0);
        exp_q.push_back({1'b1, 16'd0});
        drain(1, 20);
        cmp_queues("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
